// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/grant/response bus between the fetch stage (master)
// and instruction memory (slave).
interface if_fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one imem request in flight,
// and presents {pc+4, instruction, valid} to the IF/ID register with stall and redirect.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  if_fetch_stage_if.master         imem,
  output logic [31:0]              if_pc4_o,
  output logic [31:0]              if_inst_o,
  output logic                     if_valid_o
);

  typedef enum logic [2:0] {StBoot, StReq, StWait, StHold, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      pc4_q   <= 32'h0;
      inst_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    unique case (state_q)
      StBoot: state_d = StReq;
      StReq: begin
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          // A grant in the redirect cycle belongs to the old path; drain its response.
          state_d = imem.gnt ? StDrain : StReq;
        end else if (imem.gnt) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          state_d = imem.rvalid ? StReq : StDrain;
        end else if (imem.rvalid) begin
          inst_d  = imem.rdata;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (redirect_i) begin
          pc_d    = redirect_pc_i;
          valid_d = 1'b0;
          state_d = StReq;
        end else if (!stall_i) begin
          pc_d    = pc_plus4;
          valid_d = 1'b0;
          state_d = StReq;
        end
      end
      StDrain: begin
        if (redirect_i) pc_d = redirect_pc_i;
        // Leaving on the stale response even if redirected again avoids waiting forever.
        if (imem.rvalid) state_d = StReq;
      end
      default: state_d = StBoot;
    endcase
  end

  assign imem.req   = (state_q == StReq);
  assign imem.addr  = {pc_q[31:2], 2'b00};
  assign if_pc4_o   = pc4_q;
  assign if_inst_o  = inst_q;
  assign if_valid_o = valid_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized stall/redirect/memory timing,
// all checked each cycle against a transaction-level model of the fetch stage.
module tb_if_fetch_stage;
  localparam logic [31:0] K = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc4, if_inst;
  logic        if_valid;

  if_fetch_stage_if imem_bus ();

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem          (imem_bus),
    .if_pc4_o      (if_pc4),
    .if_inst_o     (if_inst),
    .if_valid_o    (if_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory responder: grant after a delay, respond after a latency, data = addr ^ K.
  bit          rand_mode = 0;
  int          lat_fix   = 1;
  int          gnt_cnt   = 0;
  int          resp_cnt  = 0;
  logic [31:0] resp_data;

  always @(negedge clk) begin
    imem_bus.gnt    = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = $urandom;
    if (rst) begin
      resp_cnt = 0;
      gnt_cnt  = 0;
    end else begin
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          imem_bus.rvalid = 1'b1;
          imem_bus.rdata  = resp_data;
        end
      end
      if (imem_bus.req === 1'b1) begin
        if (gnt_cnt == 0) begin
          imem_bus.gnt = 1'b1;
          resp_cnt  = rand_mode ? int'($urandom_range(1, 3)) : lat_fix;
          resp_data = imem_bus.addr ^ K;
          gnt_cnt   = rand_mode ? int'($urandom_range(0, 3)) : 0;
        end else begin
          gnt_cnt--;
        end
      end else if (rand_mode) begin
        imem_bus.gnt = 1'($urandom_range(0, 1));
      end
    end
  end

  // Transaction-level model: a request is issued whenever nothing is in flight and nothing
  // is held; a response is kept only if no redirect happened since its grant.
  logic        m_boot, m_out, m_stale, m_valid;
  logic [31:0] m_pc, m_pc4, m_inst;
  logic        exp_req, take;

  assign exp_req = !m_boot && !m_out && !m_valid;
  assign take    = exp_req && imem_bus.gnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_boot <= 1'b1; m_out <= 1'b0; m_stale <= 1'b0; m_valid <= 1'b0;
      m_pc   <= 32'h0; m_pc4 <= 32'h0; m_inst <= 32'h0;
    end else if (m_boot) begin
      m_boot <= 1'b0;
    end else if (redirect) begin
      m_pc    <= redirect_pc;
      m_valid <= 1'b0;
      m_out   <= take || (m_out && !imem_bus.rvalid);
      if (take || m_out) m_stale <= 1'b1;
    end else if (m_out && imem_bus.rvalid) begin
      m_out <= 1'b0;
      if (!m_stale) begin
        m_valid <= 1'b1;
        m_inst  <= imem_bus.rdata;
        m_pc4   <= m_pc + 32'd4;
      end
    end else if (take) begin
      m_out   <= 1'b1;
      m_stale <= 1'b0;
    end else if (m_valid && !stall) begin
      m_valid <= 1'b0;
      m_pc    <= m_pc + 32'd4;
    end
  end

  // Observation logs for the literal checks.
  logic [31:0] addr_q[$];
  logic [31:0] pc4_q[$];
  logic        valid_prev = 1'b0;

  always @(posedge clk) if (!rst && imem_bus.req && imem_bus.gnt) addr_q.push_back(imem_bus.addr);

  always @(negedge clk) begin
    if (!rst) begin
      check("req", 32'(imem_bus.req), 32'(exp_req));
      if (exp_req) check("addr", imem_bus.addr, {m_pc[31:2], 2'b00});
      check("valid", 32'(if_valid), 32'(m_valid));
      if (m_valid) begin
        check("inst", if_inst, m_inst);
        check("pc4", if_pc4, m_pc4);
      end
      if (if_valid && !valid_prev) pc4_q.push_back(if_pc4);
      valid_prev <= if_valid;
    end else begin
      valid_prev <= 1'b0;
    end
  end

  task automatic wait_valid(input string name);
    int n = 0;
    while (if_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (if_valid !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout waiting for if_valid_o, got %b, expected 1", name, if_valid);
    end
  endtask

  task automatic wait_addr(input string name, input int cnt);
    int n = 0;
    while (addr_q.size() < cnt && n < 40) begin @(negedge clk); n++; end
    if (addr_q.size() < cnt) begin
      n_checks++; n_fail++;
      $display("FAIL %s: timeout, got %0d grants, expected %0d", name, addr_q.size(), cnt);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    addr_q.delete(); pc4_q.delete();
    #1 rst = 1'b0;
  endtask

  // Redirect while a 2-cycle response is pending; the response must be dropped.
  task automatic redirect_test(input logic [31:0] tgt, input logic [31:0] exp_pc4,
                               input logic [31:0] exp_next);
    int n = 0;
    lat_fix = 2;
    stall   = 1'b0;
    while (imem_bus.req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(negedge clk);
    redirect    = 1'b1;
    redirect_pc = tgt;
    @(negedge clk);
    redirect = 1'b0;
    addr_q.delete();
    wait_addr("redir_req", 1);
    if (addr_q.size() > 0) check("redir_addr", addr_q[0], tgt);
    wait_valid("redir_valid");
    check("redir_pc4", if_pc4, exp_pc4);
    wait_addr("redir_next", 2);
    if (addr_q.size() > 1) check("redir_next_addr", addr_q[1], exp_next);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(imem_bus.req), 32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_inst", if_inst, 32'h0);
    check("rst_pc4", if_pc4, 32'h0);
    #1 rst = 1'b0;

    // Back-to-back fetch with immediate grant and 1-cycle response.
    repeat (12) @(negedge clk);
    if (addr_q.size() >= 3 && pc4_q.size() >= 3) begin
      check("seq_addr0", addr_q[0], 32'h0);
      check("seq_addr1", addr_q[1], 32'h4);
      check("seq_addr2", addr_q[2], 32'h8);
      check("seq_pc4_0", pc4_q[0], 32'h4);
      check("seq_pc4_1", pc4_q[1], 32'h8);
      check("seq_pc4_2", pc4_q[2], 32'hC);
    end else begin
      n_checks++; n_fail++;
      $display("FAIL seq_count: got %0d grants/%0d valids, expected 3/3",
               addr_q.size(), pc4_q.size());
    end

    // Stall in HOLD for 5 cycles.
    stall = 1'b1;
    pulse_reset();
    wait_valid("stall_valid");
    for (int i = 0; i < 5; i++) begin
      check("stall_inst", if_inst, 32'h0010_0093);
      check("stall_pc4", if_pc4, 32'h4);
      check("stall_valid_hold", 32'(if_valid), 32'h1);
      check("stall_noreq", 32'(imem_bus.req), 32'h0);
      @(negedge clk);
    end
    stall = 1'b0;
    addr_q.delete();
    wait_addr("stall_next", 1);
    if (addr_q.size() > 0) check("stall_next_addr", addr_q[0], 32'h4);

    redirect_test(32'h0000_0100, 32'h0000_0104, 32'h0000_0104);
    redirect_test(32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000);

    // Asynchronous reset in the middle of a 3-cycle response wait.
    lat_fix = 3;
    wait_valid("arst_prev_valid");
    begin
      int n = 0;
      while (imem_bus.req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    end
    @(posedge clk); #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(if_valid), 32'h0);
    check("arst_inst", if_inst, 32'h0);
    check("arst_pc4", if_pc4, 32'h0);
    check("arst_req", 32'(imem_bus.req), 32'h0);
    repeat (2) @(negedge clk);
    addr_q.delete();
    #1 rst = 1'b0;
    wait_addr("arst_restart", 1);
    if (addr_q.size() > 0) check("arst_restart_addr", addr_q[0], 32'h0);

    // Randomized stall, redirect and memory timing.
    rand_mode = 1'b1;
    repeat (3000) begin
      @(negedge clk);
      stall       = 1'($urandom_range(0, 1));
      redirect    = ($urandom_range(0, 9) == 0);
      redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 | 32'($urandom_range(0, 7))
                                                : $urandom;
    end
    redirect = 1'b0;
    stall    = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
